// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC selection FSM (IDLE/RUN/STALL/FLUSH) with redirect flush.
//            Define PC_SEQUENCER_PERF_CNT_EN to build the stall/redirect counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic [31:0] pc_i,
   output logic [31:0] pc_next_o,
   output logic        pc_write_o,
   output logic        flush_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      STALL = 2'b10,
      FLUSH = 2'b11
   } state_t;

   localparam logic [31:0] C_PC_STEP    = 32'd4;
   localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] w_pc_seq;
   logic        w_stall_hold;
   logic        w_redirect;

   assign w_pc_seq = pc_i + C_PC_STEP;

   always_comb begin
      w_next_state = r_state;
      pc_next_o    = pc_i;
      pc_write_o   = 1'b0;
      flush_o      = 1'b0;
      w_stall_hold = 1'b0;
      w_redirect   = 1'b0;
      if (rst_i) begin
         w_next_state = IDLE;
      end else if (!start_i) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_next_state = RUN;
            end
            RUN, STALL: begin
               // Jump outranks branch; both share the same redirect path.
               if (jump_i || branch_i) begin
                  pc_next_o    = (jump_i ? jump_target_i : branch_target_i) & C_ALIGN_MASK;
                  pc_write_o   = 1'b1;
                  flush_o      = 1'b1;
                  w_redirect   = 1'b1;
                  w_next_state = FLUSH;
               end else if (stall_i) begin
                  w_stall_hold = 1'b1;
                  w_next_state = STALL;
               end else begin
                  pc_next_o    = w_pc_seq;
                  pc_write_o   = 1'b1;
                  w_next_state = RUN;
               end
            end
            FLUSH: begin
               pc_next_o    = w_pc_seq;
               pc_write_o   = 1'b1;
               w_next_state = RUN;
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The register may still hold a stale state on the first reset edge.
   assign state_o = rst_i ? IDLE : r_state;

`ifdef PC_SEQUENCER_PERF_CNT_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if (w_stall_hold && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (w_redirect && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = 16'd0;
   assign flush_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed vector bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stall_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic [31:0] pc_i;
   logic [31:0] pc_next_o;
   logic        pc_write_o;
   logic        flush_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o;
   logic [15:0] flush_cnt_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   pc_sequencer dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .stall_i        (stall_i),
      .branch_i       (branch_i),
      .branch_target_i(branch_target_i),
      .jump_i         (jump_i),
      .jump_target_i  (jump_target_i),
      .pc_i           (pc_i),
      .pc_next_o      (pc_next_o),
      .pc_write_o     (pc_write_o),
      .flush_o        (flush_o),
      .state_o        (state_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   typedef struct {
      logic        rst;
      logic        start;
      logic        stall;
      logic        branch;
      logic [31:0] bt;
      logic        jump;
      logic [31:0] jt;
      logic [31:0] pc;
      logic [31:0] e_next;
      logic        e_write;
      logic        e_flush;
      logic [1:0]  e_state;
      logic [15:0] e_scnt;
      logic [15:0] e_fcnt;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef PC_SEQUENCER_PERF_CNT_EN
      return v;
`else
      return 16'd0;
`endif
   endfunction

   task automatic drive(input logic rst, input logic start, input logic stall,
                        input logic branch, input logic [31:0] bt,
                        input logic jump, input logic [31:0] jt, input logic [31:0] pc);
      @(negedge clk_i);
      rst_i = rst; start_i = start; stall_i = stall;
      branch_i = branch; branch_target_i = bt;
      jump_i = jump; jump_target_i = jt; pc_i = pc;
      #2;
   endtask

   function automatic vec_t mk(input logic rst, input logic start, input logic stall,
                               input logic branch, input logic [31:0] bt,
                               input logic jump, input logic [31:0] jt, input logic [31:0] pc,
                               input logic [31:0] e_next, input logic e_write, input logic e_flush,
                               input logic [1:0] e_state, input logic [15:0] e_scnt,
                               input logic [15:0] e_fcnt);
      vec_t v;
      v.rst = rst; v.start = start; v.stall = stall; v.branch = branch; v.bt = bt;
      v.jump = jump; v.jt = jt; v.pc = pc; v.e_next = e_next; v.e_write = e_write;
      v.e_flush = e_flush; v.e_state = e_state; v.e_scnt = e_scnt; v.e_fcnt = e_fcnt;
      return v;
   endfunction

   initial begin
      //               rst st  sl  br  bt            jp  jt            pc             next          w  f  state  scnt fcnt
      vecs[0]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0100, 32'h0000_0100, 0, 0, 2'b00, 0, 0);
      vecs[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0100, 32'h0000_0100, 0, 0, 2'b00, 0, 0);
      vecs[2]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0100, 32'h0000_0104, 1, 0, 2'b01, 0, 0);
      vecs[3]  = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 32'h0000_0200, 0, 0, 2'b01, 0, 0);
      vecs[4]  = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 32'h0000_0200, 0, 0, 2'b10, 1, 0);
      vecs[5]  = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 32'h0000_0200, 0, 0, 2'b10, 2, 0);
      vecs[6]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 32'h0000_0204, 1, 0, 2'b10, 3, 0);
      vecs[7]  = mk(0, 1, 0, 1, 32'h0000_4000, 1, 32'h0000_3000, 32'h0000_0204, 32'h0000_3000, 1, 1, 2'b01, 3, 0);
      vecs[8]  = mk(0, 1, 1, 1, 32'h0000_5000, 0, 32'h0,         32'h0000_3000, 32'h0000_3004, 1, 0, 2'b11, 3, 1);
      vecs[9]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 2'b01, 3, 1);
      vecs[10] = mk(0, 1, 0, 1, 32'h0000_1003, 0, 32'h0,         32'h0000_0010, 32'h0000_1000, 1, 1, 2'b01, 3, 1);
      vecs[11] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_1000, 32'h0000_1000, 0, 0, 2'b11, 3, 2);
      vecs[12] = mk(0, 0, 1, 1, 32'h0000_7000, 1, 32'h0000_8000, 32'h0000_1000, 32'h0000_1000, 0, 0, 2'b00, 3, 2);
      vecs[13] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0040, 32'h0000_0040, 0, 0, 2'b00, 3, 2);
      vecs[14] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0040, 32'h0000_0040, 0, 0, 2'b01, 3, 2);
      vecs[15] = mk(0, 1, 1, 0, 32'h0,         1, 32'h0000_2002, 32'h0000_0040, 32'h0000_2000, 1, 1, 2'b10, 4, 2);
      vecs[16] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_2000, 32'h0000_2004, 1, 0, 2'b11, 4, 3);
      vecs[17] = mk(1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0080, 32'h0000_0080, 0, 0, 2'b00, 4, 3);
      vecs[18] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0080, 32'h0000_0080, 0, 0, 2'b00, 0, 0);

      drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].bt,
               vecs[i].jump, vecs[i].jt, vecs[i].pc);
         chk($sformatf("v%0d pc_next", i), pc_next_o, vecs[i].e_next);
         chk($sformatf("v%0d pc_write", i), {31'd0, pc_write_o}, {31'd0, vecs[i].e_write});
         chk($sformatf("v%0d flush", i), {31'd0, flush_o}, {31'd0, vecs[i].e_flush});
         chk($sformatf("v%0d state", i), {30'd0, state_o}, {30'd0, vecs[i].e_state});
         chk($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt_o}, {16'd0, cnt_exp(vecs[i].e_scnt)});
         chk($sformatf("v%0d flush_cnt", i), {16'd0, flush_cnt_o}, {16'd0, cnt_exp(vecs[i].e_fcnt)});
      end

      // Reset in the middle of a stall, then released with start low.
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0500);
      drive(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0000_0500);
      drive(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0000_0500);
      chk("stall_entered", {30'd0, state_o}, 32'd2);
      drive(1, 1, 1, 1, 32'h0000_0900, 0, 32'h0, 32'h0000_0500);
      chk("rst_in_stall state", {30'd0, state_o}, 32'd0);
      chk("rst_in_stall pc_write", {31'd0, pc_write_o}, 32'd0);
      chk("rst_in_stall flush", {31'd0, flush_o}, 32'd0);
      chk("rst_in_stall pc_next", pc_next_o, 32'h0000_0500);
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0500);
      chk("post_rst state", {30'd0, state_o}, 32'd0);
      chk("post_rst pc_write", {31'd0, pc_write_o}, 32'd0);
      chk("post_rst stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
      chk("post_rst flush_cnt", {16'd0, flush_cnt_o}, 32'd0);

      // Reset during FLUSH: restart must begin in IDLE with no redirect replay.
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0600);
      drive(0, 1, 0, 1, 32'h0000_0A00, 0, 32'h0, 32'h0000_0600);
      chk("redirect flush", {31'd0, flush_o}, 32'd1);
      drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0A00);
      chk("rst_in_flush state", {30'd0, state_o}, 32'd0);
      chk("rst_in_flush pc_write", {31'd0, pc_write_o}, 32'd0);
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0A00);
      chk("restart idle state", {30'd0, state_o}, 32'd0);
      chk("restart idle pc_next", pc_next_o, 32'h0000_0A00);
      drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0000_0A00);
      chk("restart run state", {30'd0, state_o}, 32'd1);
      chk("restart run pc_next", pc_next_o, 32'h0000_0A04);
      chk("restart run flush", {31'd0, flush_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
